// File: rtl/axis_demux.sv
// axis_demux: 1:2 AXI-Stream router. Beats go to the bc (audio) output or to
// the fb (coefficient) output, selected by pi_coef_load at the first beat of a
// packet and locked until its tlast beat. Each output is fed from a 2-entry
// skid buffer, so the output side is registered and sustains 1 beat/cycle.
// Optional feature macro: AXIS_DEMUX_PKT_CNT_EN adds per-output packet counters.
//
// state  | meaning
// IDLE   | between packets; target follows pi_coef_load every cycle
// PKT_BC | inside a packet routed to bc; pi_coef_load ignored
// PKT_FB | inside a packet routed to fb; pi_coef_load ignored
module axis_demux #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  pi_clk,
  input  logic                  pi_rst_n,
  input  logic                  pi_coef_load,
  input  logic [DATA_WIDTH-1:0] pi_data_tdata,
  input  logic                  pi_data_tlast,
  input  logic                  pi_data_tvalid,
  output logic                  pi_data_tready,
  output logic [DATA_WIDTH-1:0] po_data_bc_tdata,
  output logic                  po_data_bc_tlast,
  output logic                  po_data_bc_tvalid,
  input  logic                  po_data_bc_tready,
  output logic [DATA_WIDTH-1:0] po_data_fb_tdata,
  output logic                  po_data_fb_tlast,
  output logic                  po_data_fb_tvalid,
  input  logic                  po_data_fb_tready
`ifdef AXIS_DEMUX_PKT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  po_pkt_cnt_bc,
  output logic [CNT_WIDTH-1:0]  po_pkt_cnt_fb
`endif
);

  // Buffer entries carry {tlast, tdata}; index 0 = bc, 1 = fb.
  localparam int EW = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PKT_BC = 2'd1,
    PKT_FB = 2'd2
  } state_t;

  if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_chk
    $error("axis_demux: DATA_WIDTH and CNT_WIDTH must be at least 1");
  end

  state_t          state_q, state_d;
  logic            run_q;
  logic            target_fb;
  logic            accept;
  logic [1:0]      push, pop, full, out_ready;
  logic [1:0]      cnt_q [2];
  logic [EW-1:0]   ent_q [2][2];
  logic [EW-1:0]   din;

  assign din       = {pi_data_tlast, pi_data_tdata};
  assign out_ready = {po_data_fb_tready, po_data_bc_tready};

  // Input acceptance is held off until the first clock edge after reset release.
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) run_q <= 1'b0;
    else           run_q <= 1'b1;
  end

  // Route selection, input ready and per-buffer push/pop strobes.
  always_comb begin
    target_fb = 1'b0;
    case (state_q)
      IDLE:    target_fb = pi_coef_load;
      PKT_FB:  target_fb = 1'b1;
      default: target_fb = 1'b0;
    endcase
    for (int i = 0; i < 2; i++) begin
      full[i] = (cnt_q[i] == 2'd2);
      pop[i]  = (cnt_q[i] != 2'd0) && out_ready[i];
    end
    pi_data_tready = run_q && !full[target_fb];
    accept         = pi_data_tvalid && pi_data_tready;
    push[0]        = accept && !target_fb;
    push[1]        = accept && target_fb;
  end

  // FSM next state: lock the target on a non-last beat, unlock on tlast.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (pi_data_tlast) state_d = IDLE;
      else if (target_fb) state_d = PKT_FB;
      else                state_d = PKT_BC;
    end
  end

  // FSM state register.
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Skid buffers: entry 0 is always the head, entry 1 the second-oldest beat.
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]    <= 2'd0;
        ent_q[i][0] <= '0;
        ent_q[i][1] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pop[i]) ent_q[i][0] <= ent_q[i][1];
        if (push[i]) begin
          // A beat lands in the head slot when the buffer is, or is becoming, empty.
          if (cnt_q[i] == 2'd0 || (cnt_q[i] == 2'd1 && pop[i])) ent_q[i][0] <= din;
          else                                                  ent_q[i][1] <= din;
        end
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 2'd1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 2'd1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  // Outputs come straight from the head registers; they only move on a pop.
  always_comb begin
    po_data_bc_tvalid = (cnt_q[0] != 2'd0);
    po_data_bc_tdata  = ent_q[0][0][DATA_WIDTH-1:0];
    po_data_bc_tlast  = ent_q[0][0][DATA_WIDTH];
    po_data_fb_tvalid = (cnt_q[1] != 2'd0);
    po_data_fb_tdata  = ent_q[1][0][DATA_WIDTH-1:0];
    po_data_fb_tlast  = ent_q[1][0][DATA_WIDTH];
  end

`ifdef AXIS_DEMUX_PKT_CNT_EN
  // Packet counters: one count per tlast handshake on each output, wrapping.
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      po_pkt_cnt_bc <= '0;
      po_pkt_cnt_fb <= '0;
    end else begin
      if (pop[0] && ent_q[0][0][DATA_WIDTH]) po_pkt_cnt_bc <= po_pkt_cnt_bc + 1'b1;
      if (pop[1] && ent_q[1][0][DATA_WIDTH]) po_pkt_cnt_fb <= po_pkt_cnt_fb + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_demux.sv
// Bench for axis_demux: directed packet scenarios followed by random traffic,
// checked every cycle against a queue-based model of the two output streams.
module tb_axis_demux;
  localparam int DW = 24;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          coef = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0, in_valid = 1'b0, in_ready;
  logic [DW-1:0] bc_data, fb_data;
  logic          bc_last, bc_valid, bc_ready = 1'b0;
  logic          fb_last, fb_valid, fb_ready = 1'b0;
`ifdef AXIS_DEMUX_PKT_CNT_EN
  logic [CW-1:0] cnt_bc, cnt_fb;
`endif

  always #5 clk = ~clk;

  axis_demux #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .pi_clk(clk), .pi_rst_n(rst_n), .pi_coef_load(coef),
    .pi_data_tdata(in_data), .pi_data_tlast(in_last),
    .pi_data_tvalid(in_valid), .pi_data_tready(in_ready),
    .po_data_bc_tdata(bc_data), .po_data_bc_tlast(bc_last),
    .po_data_bc_tvalid(bc_valid), .po_data_bc_tready(bc_ready),
    .po_data_fb_tdata(fb_data), .po_data_fb_tlast(fb_last),
    .po_data_fb_tvalid(fb_valid), .po_data_fb_tready(fb_ready)
`ifdef AXIS_DEMUX_PKT_CNT_EN
    , .po_pkt_cnt_bc(cnt_bc), .po_pkt_cnt_fb(cnt_fb)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: beats accepted but not yet delivered, per output, as {tlast, tdata}.
  logic [DW:0] q_bc[$];
  logic [DW:0] q_fb[$];
  bit          run = 0;
  bit          in_pkt = 0;
  bit          lock_fb = 0;
  int          pkts_bc = 0, pkts_fb = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input bit c,
                       input bit rb, input bit rf, output bit acc);
    bit tgt, exp_rdy, pb, pf;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; coef = c; bc_ready = rb; fb_ready = rf;
    #1;
    tgt     = in_pkt ? lock_fb : c;
    exp_rdy = run && ((tgt ? q_fb.size() : q_bc.size()) < 2);
    check_val("in_tready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check_val("bc_tvalid", {31'd0, bc_valid}, {31'd0, q_bc.size() > 0});
    check_val("fb_tvalid", {31'd0, fb_valid}, {31'd0, q_fb.size() > 0});
    if (q_bc.size() > 0) check_val("bc_beat", {7'd0, bc_last, bc_data}, {7'd0, q_bc[0]});
    if (q_fb.size() > 0) check_val("fb_beat", {7'd0, fb_last, fb_data}, {7'd0, q_fb[0]});
`ifdef AXIS_DEMUX_PKT_CNT_EN
    check_val("cnt_bc", {30'd0, cnt_bc}, pkts_bc % (1 << CW));
    check_val("cnt_fb", {30'd0, cnt_fb}, pkts_fb % (1 << CW));
`endif
    acc = v && exp_rdy;
    pb  = rb && q_bc.size() > 0;
    pf  = rf && q_fb.size() > 0;
    @(posedge clk);
    if (pb) begin if (q_bc[0][DW]) pkts_bc++; void'(q_bc.pop_front()); end
    if (pf) begin if (q_fb[0][DW]) pkts_fb++; void'(q_fb.pop_front()); end
    if (acc) begin
      if (tgt) q_fb.push_back({l, d});
      else     q_bc.push_back({l, d});
      in_pkt  = !l;
      lock_fb = tgt;
    end
    if (rst_n) run = 1;
  endtask

  task automatic do_reset(input int hold);
    bit acc;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q_bc.delete(); q_fb.delete();
    run = 0; in_pkt = 0; lock_fb = 0; pkts_bc = 0; pkts_fb = 0;
    for (int i = 0; i < hold; i++) cycle(1'b1, DW'(i + 'h55), 1'b0, i[0], 1'b1, 1'b1, acc);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input bit rb, input bit rf);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, rb, rf, acc);
  endtask

  // Sends n beats base..base+n-1; pi_coef_load flips to ~c from beat index sw on.
  task automatic send_pkt(input int n, input int base, input bit c, input int sw,
                          input bit rb, input bit rf);
    bit acc;
    int tries;
    for (int i = 0; i < n; i++) begin
      tries = 0;
      do begin
        cycle(1'b1, DW'(base + i), i == n - 1, (i < sw) ? c : !c, rb, rf, acc);
        tries++;
      end while (!acc && tries < 50);
      if (!acc) check_val("send_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    // Reset with tvalid held high, then first-beat latency after release.
    do_reset(4);
    idle(2, 1'b1, 1'b1);
    send_pkt(1, 'h0A0A0A, 1'b0, 1, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);
    // Four-beat packet to bc.
    send_pkt(4, 1, 1'b0, 4, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    // Eight-beat packet to fb with pi_coef_load dropping after beat 3; next goes to bc.
    send_pkt(8, 'h100, 1'b1, 3, 1'b1, 1'b1);
    send_pkt(2, 'h200, 1'b0, 2, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    // Backpressure on fb, then release.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'('h300 + i), 1'b0, 1'b1, 1'b1, 1'b0, acc);
    idle(2, 1'b1, 1'b0);
    send_pkt(3, 'h303, 1'b1, 3, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    // bc stalled holding two beats while an fb packet streams past.
    send_pkt(2, 'h400, 1'b0, 2, 1'b0, 1'b1);
    send_pkt(6, 'h500, 1'b1, 6, 1'b0, 1'b1);
    idle(4, 1'b1, 1'b1);
    // Packet counters: 3 bc packets, 2 single-beat fb packets, then 2 more bc (wraps).
    do_reset(2);
    for (int p = 0; p < 3; p++) send_pkt(p + 1, 'h600 + 16 * p, 1'b0, 8, 1'b1, 1'b1);
    send_pkt(1, 'h700, 1'b1, 1, 1'b1, 1'b1);
    send_pkt(1, 'h701, 1'b1, 1, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
`ifdef AXIS_DEMUX_PKT_CNT_EN
    check_val("cnt_bc_3", {30'd0, cnt_bc}, 32'd3);
    check_val("cnt_fb_2", {30'd0, cnt_fb}, 32'd2);
`endif
    send_pkt(2, 'h800, 1'b0, 2, 1'b1, 1'b1);
    send_pkt(2, 'h810, 1'b0, 2, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
`ifdef AXIS_DEMUX_PKT_CNT_EN
    check_val("cnt_bc_wrap", {30'd0, cnt_bc}, 32'd1);
`endif
    // Random traffic, with one reset landing mid-stream.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset(3);
      cycle($urandom_range(3, 0) != 0, DW'($urandom), $urandom_range(3, 0) == 0,
            1'($urandom_range(1, 0)), $urandom_range(2, 0) != 0,
            $urandom_range(2, 0) != 0, acc);
    end
    idle(4, 1'b1, 1'b1);
    check_val("drain_bc", q_bc.size(), 32'd0);
    check_val("drain_fb", q_fb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
